// File: rtl/cache_pkg.sv
// Shared types and helpers for the key/value cell-array controller.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_GET = 2'd0,
        OP_PUT = 2'd1,
        OP_DEL = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_MISS = 2'd1,
        ST_FULL = 2'd2,
        ST_ERR  = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_EXEC,
        S_RESP
    } state_e;

    localparam int NUM_CELLS_DEF = 8;
    localparam int CNT_W         = $clog2(NUM_CELLS_DEF + 1);
    // Widest cell vector first_set() accepts; narrower vectors are zero-extended.
    localparam int MAX_CELLS     = 32;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int first_set(input logic [MAX_CELLS-1:0] vec);
        first_set = 0;
        for (int i = MAX_CELLS - 1; i >= 0; i--) begin
            if (vec[i]) first_set = i;
        end
    endfunction

endpackage

// File: rtl/cache_key_matcher.sv
// Fully-associative key compare across all cells plus lowest-free-cell search.
module cache_key_matcher
    import cache_pkg::*;
#(
    parameter int NUM_CELLS = 8,
    parameter int KEY_WIDTH = 8,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic [KEY_WIDTH-1:0]           key_i,
    input  logic [NUM_CELLS*KEY_WIDTH-1:0] cell_key_i,
    input  logic [NUM_CELLS-1:0]           cell_used_i,
    output logic                           hit_o,
    output logic [IDX_W-1:0]               hit_idx_o,
    output logic                           free_o,
    output logic [IDX_W-1:0]               free_idx_o
);

    logic [NUM_CELLS-1:0] hit_vec;
    logic [NUM_CELLS-1:0] free_vec;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            hit_vec[i] = cell_used_i[i] && (cell_key_i[i*KEY_WIDTH +: KEY_WIDTH] == key_i);
        end
        free_vec = ~cell_used_i;
    end

    // Lowest index wins, so pre-existing duplicate keys resolve deterministically.
    assign hit_o      = |hit_vec;
    assign hit_idx_o  = IDX_W'(first_set(MAX_CELLS'(hit_vec)));
    assign free_o     = |free_vec;
    assign free_idx_o = IDX_W'(first_set(MAX_CELLS'(free_vec)));

endmodule

// File: rtl/cache_op_controller.sv
// GET/PUT/DEL sequencer for a flat key/value cell array: IDLE -> LOOKUP -> EXEC -> RESP.
module cache_op_controller
    import cache_pkg::*;
#(
    parameter int NUM_CELLS   = 8,
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [1:0]                       req_op,
    input  logic [KEY_WIDTH-1:0]             req_key,
    input  logic [VALUE_WIDTH-1:0]           req_value,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [1:0]                       resp_status,
    output logic [VALUE_WIDTH-1:0]           resp_value,
    output logic [NUM_CELLS-1:0]             cell_write_op,
    output logic [KEY_WIDTH-1:0]             cell_key_in,
    output logic [VALUE_WIDTH-1:0]           cell_value_in,
    input  logic [NUM_CELLS*KEY_WIDTH-1:0]   cell_key_out,
    input  logic [NUM_CELLS*VALUE_WIDTH-1:0] cell_value_out,
    input  logic [NUM_CELLS-1:0]             cell_used,
    output logic [$clog2(NUM_CELLS+1)-1:0]   used_count
);

    localparam int IDX_W = $clog2(NUM_CELLS);
    localparam int CW    = $clog2(NUM_CELLS + 1);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic                   hit_q, hit_d, free_q, free_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
    status_e                status_q, status_d;
    logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
    logic [NUM_CELLS-1:0]   wop_q, wop_d;
    logic [KEY_WIDTH-1:0]   wkey_q, wkey_d;
    logic [VALUE_WIDTH-1:0] wval_q, wval_d;
    logic [CW-1:0]          count_q, count_d;

    logic                   m_hit, m_free;
    logic [IDX_W-1:0]       m_hit_idx, m_free_idx;

    cache_key_matcher #(
        .NUM_CELLS (NUM_CELLS),
        .KEY_WIDTH (KEY_WIDTH),
        .IDX_W     (IDX_W)
    ) u_matcher (
        .key_i       (key_q),
        .cell_key_i  (cell_key_out),
        .cell_used_i (cell_used),
        .hit_o       (m_hit),
        .hit_idx_o   (m_hit_idx),
        .free_o      (m_free),
        .free_idx_o  (m_free_idx)
    );

    assign req_ready     = (state_q == S_IDLE) && !rst;
    assign resp_valid    = (state_q == S_RESP);
    assign resp_status   = status_q;
    assign resp_value    = rvalue_q;
    assign cell_write_op = wop_q;
    assign cell_key_in   = wkey_q;
    assign cell_value_in = wval_q;
    assign used_count    = count_q;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        op_d       = op_q;
        key_d      = key_q;
        value_d    = value_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        free_d     = free_q;
        free_idx_d = free_idx_q;
        status_d   = status_q;
        rvalue_d   = rvalue_q;
        wop_d      = '0;
        wkey_d     = wkey_q;
        wval_d     = wval_q;
        count_d    = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = op_e'(req_op);
                    key_d   = req_key;
                    value_d = req_value;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d      = m_hit;
                hit_idx_d  = m_hit_idx;
                free_d     = m_free;
                free_idx_d = m_free_idx;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                status_d = ST_OK;
                rvalue_d = '0;
                if (key_q == '0 || op_q == OP_ILL) begin
                    status_d = ST_ERR;
                end else begin
                    unique case (op_q)
                        OP_GET: begin
                            if (hit_q) rvalue_d = cell_value_out[hit_idx_q*VALUE_WIDTH +: VALUE_WIDTH];
                            else       status_d = ST_MISS;
                        end
                        OP_PUT: begin
                            // A hit always overwrites in place, which keeps keys unique.
                            if (hit_q) begin
                                wop_d[hit_idx_q] = 1'b1;
                                wkey_d           = key_q;
                                wval_d           = value_q;
                            end else if (free_q) begin
                                wop_d[free_idx_q] = 1'b1;
                                wkey_d            = key_q;
                                wval_d            = value_q;
                                if (count_q != CW'(NUM_CELLS)) count_d = count_q + CW'(1);
                            end else begin
                                status_d = ST_FULL;
                            end
                        end
                        OP_DEL: begin
                            if (hit_q) begin
                                wop_d[hit_idx_q] = 1'b1;
                                wkey_d           = '0;
                                wval_d           = '0;
                                if (count_q != '0) count_d = count_q - CW'(1);
                            end else begin
                                status_d = ST_MISS;
                            end
                        end
                        default: status_d = ST_ERR;
                    endcase
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_GET;
            key_q      <= '0;
            value_q    <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            free_q     <= 1'b0;
            free_idx_q <= '0;
            status_q   <= ST_OK;
            rvalue_q   <= '0;
            wop_q      <= '0;
            wkey_q     <= '0;
            wval_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            key_q      <= key_d;
            value_q    <= value_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            free_q     <= free_d;
            free_idx_q <= free_idx_d;
            status_q   <= status_d;
            rvalue_q   <= rvalue_d;
            wop_q      <= wop_d;
            wkey_q     <= wkey_d;
            wval_q     <= wval_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_cache_op_controller.sv
// Scoreboard bench for cache_op_controller with a behavioural cell array model.
module tb_cache_op_controller;

    localparam int NC = 8;
    localparam int KW = 8;
    localparam int VW = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_op = 2'd0;
    logic [KW-1:0]  req_key = '0;
    logic [VW-1:0]  req_value = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [1:0]     resp_status;
    logic [VW-1:0]  resp_value;
    logic [NC-1:0]  cell_write_op;
    logic [KW-1:0]  cell_key_in;
    logic [VW-1:0]  cell_value_in;
    logic [NC*KW-1:0] cell_key_out;
    logic [NC*VW-1:0] cell_value_out;
    logic [NC-1:0]  cell_used;
    logic [3:0]     used_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [1:0]    status;
        logic [VW-1:0] value;
        logic [NC-1:0] strobe;
        logic [KW-1:0] key_in;
        logic [VW-1:0] val_in;
        logic [3:0]    count;
        int            t_resp;
    } exp_t;

    exp_t sb_q[$];

    cache_op_controller #(.NUM_CELLS(NC), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_key        (req_key),
        .req_value      (req_value),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_status    (resp_status),
        .resp_value     (resp_value),
        .cell_write_op  (cell_write_op),
        .cell_key_in    (cell_key_in),
        .cell_value_in  (cell_value_in),
        .cell_key_out   (cell_key_out),
        .cell_value_out (cell_value_out),
        .cell_used      (cell_used),
        .used_count     (used_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cell array model: one-hot strobe writes the broadcast key/value.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_key_out   <= '0;
            cell_value_out <= '0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (cell_write_op[i]) begin
                    cell_key_out[i*KW +: KW]   <= cell_key_in;
                    cell_value_out[i*VW +: VW] <= cell_value_in;
                end
            end
        end
    end

    always_comb begin
        cell_used = '0;
        for (int i = 0; i < NC; i++) cell_used[i] = (cell_key_out[i*KW +: KW] != '0);
    end

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares the first cycle of each response against the scoreboard head.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("latency", 64'(cyc), 64'(e.t_resp));
                    check("status", 64'(resp_status), 64'(e.status));
                    check("value", resp_value, e.value);
                    check("strobe", 64'(cell_write_op), 64'(e.strobe));
                    check("used_count", 64'(used_count), 64'(e.count));
                    if (e.strobe != '0) begin
                        check("cell_key_in", 64'(cell_key_in), 64'(e.key_in));
                        check("cell_value_in", cell_value_in, e.val_in);
                    end
                end
            end else if (cell_write_op != '0) begin
                check("stray_strobe", 64'(cell_write_op), 64'(0));
            end
            prev_valid = resp_valid;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                         input logic [1:0] es, input logic [VW-1:0] ev, input logic [NC-1:0] estr,
                         input logic [KW-1:0] ekey, input logic [VW-1:0] eval, input logic [3:0] ecnt);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 64'(req_ready), 64'(1));
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_value = val;
        e.status = es;   e.value  = ev;   e.strobe = estr;
        e.key_in = ekey; e.val_in = eval; e.count  = ecnt;
        e.t_resp = cyc + 3;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic wait_resp_valid();
        int n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) check("resp_valid_timeout", 64'(resp_valid), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int popc;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_status", 64'(resp_status), 64'(0));
        check("rst_resp_value", resp_value, 64'(0));
        check("rst_write_op", 64'(cell_write_op), 64'(0));
        check("rst_key_in", 64'(cell_key_in), 64'(0));
        check("rst_value_in", cell_value_in, 64'(0));
        check("rst_used_count", 64'(used_count), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'(1));

        // 1: first PUT allocates cell 0
        issue(2'd1, 8'h05, 64'hDEAD, 2'd0, 64'h0, 8'h01, 8'h05, 64'hDEAD, 4'd1);
        drain();
        // 2: GET hit and miss
        issue(2'd0, 8'h05, 64'h0, 2'd0, 64'hDEAD, 8'h00, 8'h00, 64'h0, 4'd1);
        issue(2'd0, 8'h07, 64'h0, 2'd1, 64'h0,    8'h00, 8'h00, 64'h0, 4'd1);
        // 3: PUT hit overwrites in place
        issue(2'd1, 8'h05, 64'hBEEF, 2'd0, 64'h0, 8'h01, 8'h05, 64'hBEEF, 4'd1);
        issue(2'd0, 8'h05, 64'h0, 2'd0, 64'hBEEF, 8'h00, 8'h00, 64'h0, 4'd1);
        drain();

        // 5: ERR cases, with a 5-cycle resp_ready stall on the first
        resp_ready = 1'b0;
        issue(2'd1, 8'h00, 64'h1234, 2'd3, 64'h0, 8'h00, 8'h00, 64'h0, 4'd1);
        wait_resp_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_resp_valid", 64'(resp_valid), 64'(1));
            check("stall_status", 64'(resp_status), 64'(3));
            check("stall_value", resp_value, 64'(0));
            check("stall_req_ready", 64'(req_ready), 64'(0));
        end
        resp_ready = 1'b1;
        drain();
        issue(2'd3, 8'h11, 64'h77, 2'd3, 64'h0, 8'h00, 8'h00, 64'h0, 4'd1);
        drain();

        // 6: reset during EXEC of a PUT aborts it
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_key = 8'h20; req_value = 64'h4242;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_write_op", 64'(cell_write_op), 64'(0));
        check("abort_resp_valid", 64'(resp_valid), 64'(0));
        check("abort_used_count", 64'(used_count), 64'(0));
        check("abort_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        check("abort_write_op_late", 64'(cell_write_op), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_req_ready", 64'(req_ready), 64'(1));
        check("post_abort_resp_valid", 64'(resp_valid), 64'(0));
        check("post_abort_used_count", 64'(used_count), 64'(0));

        // 4: fill keys 1..8 into cells 0..7, then FULL, DEL, re-allocate
        for (int k = 1; k <= 8; k++) begin
            issue(2'd1, 8'(k), 64'(256 + k), 2'd0, 64'h0, 8'(1 << (k - 1)), 8'(k), 64'(256 + k), 4'(k));
        end
        issue(2'd1, 8'h09, 64'h999, 2'd2, 64'h0, 8'h00, 8'h00, 64'h0, 4'd8);
        issue(2'd2, 8'h03, 64'h0,   2'd0, 64'h0, 8'h04, 8'h00, 64'h0, 4'd7);
        issue(2'd1, 8'h09, 64'h999, 2'd0, 64'h0, 8'h04, 8'h09, 64'h999, 4'd8);
        issue(2'd0, 8'h09, 64'h0,   2'd0, 64'h999, 8'h00, 8'h00, 64'h0, 4'd8);
        issue(2'd0, 8'h06, 64'h0,   2'd0, 64'h106, 8'h00, 8'h00, 64'h0, 4'd8);
        issue(2'd2, 8'h03, 64'h0,   2'd1, 64'h0, 8'h00, 8'h00, 64'h0, 4'd8);
        drain();
        @(negedge clk);
        popc = $countones(cell_used);
        check("count_vs_popcount", 64'(used_count), 64'(popc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
